// File: rtl/negate_pipe.sv
// negate_pipe: two-stage valid/ready pipeline applying pass, one's complement,
// two's complement (negate) or absolute value to a WIDTH-bit signed operand.
// Latency 2 cycles, full throughput, 2-entry capacity, no data loss under stall.
//
// Optional feature: define NEGATE_PIPE_SAT_EN to saturate overflowing results
// (negate/abs of the most-negative value) to the most-positive value instead
// of wrapping back to the most-negative value.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand present
//   in_ready   unit can accept an operand this cycle (combinational from out_ready)
//   in_data    operand, two's-complement signed
//   in_mode    00 pass, 01 one's complement, 10 negate, 11 absolute value
//   out_valid  result present
//   out_ready  consumer accepts result this cycle
//   out_data   result
//   out_ovf    result not representable
//   out_zero   out_data == 0
//   out_neg    out_data sign bit
module negate_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_inc;
  logic             s1_min;

  // Stage 1 input decode
  logic             op_neg_c;
  logic             inv_c;
  logic             inc_c;
  logic             min_c;

  // Stage 2 next-value logic
  logic             s2_adv_c;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;
  logic [WIDTH-1:0] res_c;

  // Operand decode: abs only inverts/increments negative operands.
  always_comb begin
    op_neg_c = in_data[WIDTH-1];
    inv_c    = 1'b0;
    inc_c    = 1'b0;
    unique case (in_mode)
      MODE_PASS: begin
        inv_c = 1'b0;
        inc_c = 1'b0;
      end
      MODE_ONES: begin
        inv_c = 1'b1;
        inc_c = 1'b0;
      end
      MODE_NEG: begin
        inv_c = 1'b1;
        inc_c = 1'b1;
      end
      MODE_ABS: begin
        inv_c = op_neg_c;
        inc_c = op_neg_c;
      end
      default: begin
        inv_c = 1'b0;
        inc_c = 1'b0;
      end
    endcase
    min_c = (in_data == MIN_VAL);
  end

  // Handshake: stage 2 refills when empty or draining; stage 1 follows it.
  always_comb begin
    s2_adv_c = !out_valid || out_ready;
    in_ready = !s1_valid || s2_adv_c;
  end

  // Increment, overflow detection and optional saturation.
  always_comb begin
    sum_c = s1_data + WIDTH'(s1_inc);
    ovf_c = s1_min && s1_inc;
`ifdef NEGATE_PIPE_SAT_EN
    res_c = ovf_c ? MAX_VAL : sum_c;
`else
    res_c = sum_c;
`endif
  end

  // Stage 1 register: payload loads only on input transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inc   <= 1'b0;
      s1_min   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= inv_c ? ~in_data : in_data;
        s1_inc  <= inc_c;
        s1_min  <= min_c;
      end
    end
  end

  // Stage 2 / output register: holds steady while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_c;
        out_ovf  <= ovf_c;
        out_zero <= (res_c == '0);
        out_neg  <= res_c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_negate_pipe.sv
// Directed bench for negate_pipe at WIDTH=8, plus WIDTH=16 and WIDTH=2 instances,
// followed by a random-handshake soak against an arithmetic reference model.
module tb_negate_pipe;

`ifdef NEGATE_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset_n;

  // WIDTH=8 instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] in_mode;
  logic       out_ovf, out_zero, out_neg;

  // WIDTH=16 instance
  logic        w16_in_valid, w16_in_ready, w16_out_valid;
  logic [15:0] w16_in_data, w16_out_data;
  logic [1:0]  w16_in_mode;
  logic        w16_out_ovf, w16_out_zero, w16_out_neg;

  // WIDTH=2 instance
  logic       w2_in_valid, w2_in_ready, w2_out_valid;
  logic [1:0] w2_in_data, w2_out_data;
  logic [1:0] w2_in_mode;
  logic       w2_out_ovf, w2_out_zero, w2_out_neg;

  int checks = 0;
  int fails  = 0;
  logic [10:0] q[$];
  logic [10:0] exp_w;

  negate_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
  );

  negate_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_data(w16_in_data), .in_mode(w16_in_mode),
    .out_valid(w16_out_valid), .out_ready(1'b1), .out_data(w16_out_data),
    .out_ovf(w16_out_ovf), .out_zero(w16_out_zero), .out_neg(w16_out_neg)
  );

  negate_pipe #(.WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(w2_in_valid), .in_ready(w2_in_ready), .in_data(w2_in_data), .in_mode(w2_in_mode),
    .out_valid(w2_out_valid), .out_ready(1'b1), .out_data(w2_out_data),
    .out_ovf(w2_out_ovf), .out_zero(w2_out_zero), .out_neg(w2_out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic o, input logic z, input logic n);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, "_res"}, 32'({out_data, out_ovf, out_zero, out_neg}), 32'({d, o, z, n}));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic on the signed operand, then range handling.
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] m);
    int sv;
    int res;
    logic o;
    sv = int'($signed(d));
    case (m)
      2'd0:    res = sv;
      2'd1:    res = -sv - 1;
      2'd2:    res = -sv;
      default: res = (sv < 0) ? -sv : sv;
    endcase
    o = (res > 127);
    if (o) res = SAT ? 127 : -128;
    return {8'(res), o, (res == 0), (res < 0)};
  endfunction

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 2'b00);
    w16_in_valid = 1'b0; w16_in_data = '0; w16_in_mode = '0;
    w2_in_valid = 1'b0;  w2_in_data = '0;  w2_in_mode = '0;

    // Reset state
    #3;
    chk("rst_out", 32'({out_valid, out_data, out_ovf, out_zero, out_neg}), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic modes, one operand per cycle
    drive(1'b1, 8'h05, 2'b00); tick(); chk_out("lat0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 2'b01); tick(); chk_out("pass05", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 2'b10); tick(); chk_out("ones05", 1'b1, 8'hFA, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h05, 2'b11); tick(); chk_out("neg05", 1'b1, 8'hFB, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hFB, 2'b11); tick(); chk_out("abs05", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 2'b10); tick(); chk_out("absFB", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h80, 2'b10); tick(); chk_out("neg00", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h00, 2'b01); tick();
    chk_out("neg80", 1'b1, SAT ? 8'h7F : 8'h80, 1'b1, 1'b0, !SAT);
    drive(1'b1, 8'h80, 2'b11); tick(); chk_out("ones00", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 2'b00); tick();
    chk_out("abs80", 1'b1, SAT ? 8'h7F : 8'h80, 1'b1, 1'b0, !SAT);
    tick(); chk_out("drained", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Back-pressure: 01..06 negated, out_ready low for 5 edges
    drive(1'b1, 8'h01, 2'b10); tick();
    drive(1'b1, 8'h02, 2'b10); tick();
    chk_out("bp_first", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 2'b10);
    out_ready = 1'b0;
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("bp_hold", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("bp_drain", 1'b1, 8'hFE - 8'(k), 1'b0, 1'b0, 1'b1);
      if (k < 3) drive(1'b1, 8'h04 + 8'(k), 2'b10);
      else drive(1'b0, 8'h00, 2'b00);
    end
    tick(); chk_out("bp_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset with two operands in flight
    drive(1'b1, 8'h11, 2'b10); tick();
    drive(1'b1, 8'h22, 2'b10); tick();
    drive(1'b0, 8'h00, 2'b00);
    chk_out("mid_before", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({out_valid, out_data, out_ovf, out_zero, out_neg}), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); chk_out("mid_no_stale", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 2'b01); tick(); chk_out("mid_lat1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 2'b00); tick(); chk_out("mid_first", 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("mid_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Width generality
    w16_in_valid = 1'b1; w16_in_data = 16'h8000; w16_in_mode = 2'b10;
    w2_in_valid = 1'b1;  w2_in_data = 2'b10;     w2_in_mode = 2'b11;
    tick();
    w16_in_data = 16'h0005; w16_in_mode = 2'b10;
    w2_in_data = 2'b01;     w2_in_mode = 2'b10;
    tick();
    chk("w16_min", 32'({w16_out_valid, w16_out_data, w16_out_ovf, w16_out_zero, w16_out_neg}),
        32'({1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b0, !SAT}));
    chk("w2_min", 32'({w2_out_valid, w2_out_data, w2_out_ovf, w2_out_zero, w2_out_neg}),
        32'({1'b1, SAT ? 2'b01 : 2'b10, 1'b1, 1'b0, !SAT}));
    w16_in_valid = 1'b0; w2_in_valid = 1'b0;
    tick();
    chk("w16_neg5", 32'({w16_out_valid, w16_out_data, w16_out_ovf, w16_out_zero, w16_out_neg}),
        32'({1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b1}));
    chk("w2_neg1", 32'({w2_out_valid, w2_out_data, w2_out_ovf, w2_out_zero, w2_out_neg}),
        32'({1'b1, 2'b11, 1'b0, 1'b0, 1'b1}));

    // Random-handshake soak against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_ready) chk("soak_in_ready", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("soak_extra", 32'(out_valid), 32'd0);
        else begin
          exp_w = q.pop_front();
          chk("soak_res", 32'({out_data, out_ovf, out_zero, out_neg}), 32'(exp_w));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("soak_extra", 32'(out_valid), 32'd0);
        else begin
          exp_w = q.pop_front();
          chk("soak_res", 32'({out_data, out_ovf, out_zero, out_neg}), 32'(exp_w));
        end
      end
      tick();
    end
    chk("soak_lost", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
